// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants for the data-side memory request stage
// Exception codes, FSM state encoding, access size encoding and alignment helper.
package dmem_pkg;

  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRANS = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_EXC   = 2'd3;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Size code 3 is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      default:   return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_exc_check.sv
// rtl/dmem_exc_check.sv - priority encoder for TLB and alignment exceptions
// Alignment (ALE) check is compiled in only when DMEM_ALIGN_CHECK_EN is defined.
module dmem_exc_check
  import dmem_pkg::*;
(
  input  logic       trans_en,
  input  logic [1:0] addr_lo,
  input  logic [1:0] size,
  input  logic       wr,
  input  logic [1:0] plv,
  input  logic       tlb_found,
  input  logic       tlb_v,
  input  logic       tlb_d,
  input  logic [1:0] tlb_plv,
  output logic       exc_hit,
  output logic [5:0] exc_ecode
);

  logic misaligned;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(size, addr_lo);
`else
  logic unused_align;
  assign unused_align = ^{size, addr_lo};
  assign misaligned   = 1'b0;
`endif

  // ALE applies in every mapping mode; TLB checks only for mapped addresses.
  always_comb begin
    exc_hit   = 1'b1;
    exc_ecode = ECODE_ALE;
    if (misaligned) begin
      exc_ecode = ECODE_ALE;
    end else if (!trans_en) begin
      exc_hit   = 1'b0;
      exc_ecode = 6'h00;
    end else if (!tlb_found) begin
      exc_ecode = ECODE_TLBR;
    end else if (!tlb_v) begin
      exc_ecode = wr ? ECODE_PIS : ECODE_PIL;
    end else if (plv > tlb_plv) begin
      exc_ecode = ECODE_PPI;
    end else if (wr && !tlb_d) begin
      exc_ecode = ECODE_PME;
    end else begin
      exc_hit   = 1'b0;
      exc_ecode = 6'h00;
    end
  end

endmodule

// File: rtl/dmem_req_stage.sv
// rtl/dmem_req_stage.sv - data-side memory request stage between EX/MEM and the dcache
// One request in flight; ALE checking selected by DMEM_ALIGN_CHECK_EN.
module dmem_req_stage
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_vaddr,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_plv,
  input  logic        flush,
  output logic [31:0] at_vaddr,
  input  logic        at_trans_en,
  input  logic [7:0]  at_index,
  input  logic [19:0] at_tag,
  input  logic [3:0]  at_offset,
  input  logic        at_tlb_found,
  input  logic        at_tlb_v,
  input  logic        at_tlb_d,
  input  logic [1:0]  at_tlb_mat,
  input  logic [1:0]  at_tlb_plv,
  input  logic [1:0]  at_direct_mat,
  output logic        dc_valid,
  input  logic        dc_ready,
  output logic        dc_wr,
  output logic [7:0]  dc_index,
  output logic [19:0] dc_tag,
  output logic [3:0]  dc_offset,
  output logic [3:0]  dc_wstrb,
  output logic [31:0] dc_wdata,
  output logic        dc_uncached,
  output logic        exc_valid,
  output logic [5:0]  exc_ecode,
  output logic [31:0] exc_badv
);

  logic [1:0]  state;
  logic [31:0] r_vaddr;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [1:0]  r_plv;

  logic        chk_hit;
  logic [5:0]  chk_ecode;
  logic [1:0]  eff_mat;

  assign req_ready = (state == ST_IDLE);
  assign at_vaddr  = r_vaddr;
  assign eff_mat   = at_trans_en ? at_tlb_mat : at_direct_mat;

  dmem_exc_check u_exc_check (
    .trans_en  (at_trans_en),
    .addr_lo   (r_vaddr[1:0]),
    .size      (r_size),
    .wr        (r_wr),
    .plv       (r_plv),
    .tlb_found (at_tlb_found),
    .tlb_v     (at_tlb_v),
    .tlb_d     (at_tlb_d),
    .tlb_plv   (at_tlb_plv),
    .exc_hit   (chk_hit),
    .exc_ecode (chk_ecode)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      r_vaddr     <= 32'h0;
      r_wr        <= 1'b0;
      r_size      <= 2'd0;
      r_wstrb     <= 4'h0;
      r_wdata     <= 32'h0;
      r_plv       <= 2'd0;
      dc_valid    <= 1'b0;
      dc_wr       <= 1'b0;
      dc_index    <= 8'h0;
      dc_tag      <= 20'h0;
      dc_offset   <= 4'h0;
      dc_wstrb    <= 4'h0;
      dc_wdata    <= 32'h0;
      dc_uncached <= 1'b0;
      exc_valid   <= 1'b0;
      exc_ecode   <= 6'h0;
      exc_badv    <= 32'h0;
    end else begin
      exc_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && !flush) begin
            r_vaddr <= req_vaddr;
            r_wr    <= req_wr;
            r_size  <= req_size;
            r_wstrb <= req_wstrb;
            r_wdata <= req_wdata;
            r_plv   <= req_plv;
            state   <= ST_TRANS;
          end
        end
        ST_TRANS: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (chk_hit) begin
            exc_valid <= 1'b1;
            exc_ecode <= chk_ecode;
            exc_badv  <= r_vaddr;
            state     <= ST_EXC;
          end else begin
            dc_valid    <= 1'b1;
            dc_wr       <= r_wr;
            dc_index    <= at_index;
            dc_tag      <= at_tag;
            dc_offset   <= at_offset;
            dc_wstrb    <= r_wstrb;
            dc_wdata    <= r_wdata;
            dc_uncached <= (eff_mat == 2'd0);
            state       <= ST_ISSUE;
          end
        end
        // A flush cannot withdraw a request the dcache may already have seen.
        ST_ISSUE: begin
          if (dc_ready) begin
            dc_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_req_stage.md
# dmem_req_stage

Data-side memory request stage between the EX/MEM pipeline and the data cache. It sits directly downstream of `addr_trans` and performs these steps:
- Holds one load/store request and drives its virtual address into the data translation port.
- Checks the returned TLB attributes and raises TLB/alignment exceptions.
- Issues the translated request to the dcache with a valid/ready handshake.

Only one request is in flight at a time.

## Interface
Parameters:
- none.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1, `req_ready` out 1: pipeline request handshake.
- `req_vaddr` in 32: virtual address.
- `req_wr` in 1: 1 = store.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_wstrb` in 4, `req_wdata` in 32: store data.
- `req_plv` in 2: CRMD.PLV at issue.
- `flush` in 1: pipeline flush (exception or ertn).
- `at_vaddr` out 32: address driven to `addr_trans` data port.
- `at_trans_en` in 1: 1 = address is TLB-mapped.
- `at_index` in 8, `at_tag` in 20, `at_offset` in 4: translated cache fields.
- `at_tlb_found`, `at_tlb_v`, `at_tlb_d` in 1: TLB hit and attribute bits.
- `at_tlb_mat` in 2, `at_tlb_plv` in 2: TLB memory type and privilege.
- `at_direct_mat` in 2: MAT for DA/DMW mapping.
- `dc_valid` out 1, `dc_ready` in 1: dcache request handshake.
- `dc_wr` out 1, `dc_index` out 8, `dc_tag` out 20, `dc_offset` out 4: dcache request fields.
- `dc_wstrb` out 4, `dc_wdata` out 32, `dc_uncached` out 1: store data and cacheability.
- `exc_valid` out 1: one-cycle exception pulse.
- `exc_ecode` out 6, `exc_badv` out 32: exception code and bad virtual address.

## Operation
- FSM states: IDLE, TRANS, ISSUE, EXC. `req_ready` = (state == IDLE).
- IDLE:
  - On `req_valid && req_ready && !flush`: latch vaddr, wr, size, wstrb, wdata, plv; go to TRANS.
  - `flush` in the same cycle blocks acceptance.
- TRANS:
  - `at_vaddr` = latched vaddr. In every other state `at_vaddr` also holds the latched vaddr (0 after reset).
  - Evaluate the exception checks (first match wins, see below) and register `at_*` results into the issue registers.
  - Any exception: go to EXC. No exception: go to ISSUE.
  - `flush` in TRANS: go to IDLE, nothing issued, no exception.
- Exception checks, applied only when `at_trans_en`, except ALE (first match wins):
  1. ALE 0x09: misaligned access (`ALIGN_CHECK_EN` only).
  2. TLBR 0x3F: `!at_tlb_found`.
  3. PIL 0x01 (load) or PIS 0x02 (store): `!at_tlb_v`.
  4. PPI 0x07: `req_plv > at_tlb_plv`.
  5. PME 0x04: store && `!at_tlb_d`.
- ISSUE:
  - `dc_valid` = 1 with all `dc_*` fields stable until `dc_valid && dc_ready`; then go to IDLE.
  - `flush` in ISSUE does not withdraw `dc_valid`. The request completes, then the stage goes to IDLE.
- `dc_uncached` = (MAT == 0). MAT is `at_tlb_mat` when `at_trans_en`, else `at_direct_mat`.
- EXC:
  - `exc_valid` = 1 for exactly one cycle, with `exc_ecode` and `exc_badv` = latched vaddr; then go to IDLE.
  - `flush` in EXC does not suppress the pulse.

## Timing
- Reset values:
  - State IDLE, so `req_ready` = 1.
  - `dc_valid`, `exc_valid`, `dc_wr`, `dc_uncached` = 0.
  - All data and field outputs = 0.
- Latency:
  - Accept at cycle 0, TRANS at cycle 1, `dc_valid` earliest at cycle 2.
  - `exc_valid` at cycle 2 on an exception.
  - Minimum accept-to-accept spacing is 3 cycles with `dc_ready` tied high.
- `dc_*` and `exc_*` outputs are registered. `at_vaddr` and `req_ready` are decoded from registered state.
- Reset asserted mid-operation: return to IDLE immediately and drop any pending request; no exception pulse and no `dc_valid` follow.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - ALE check active, highest priority.
  - Misaligned means half with vaddr[0] = 1, or word with vaddr[1:0] != 0.
  - Applies in all mapping modes.
- Not defined:
  - No ALE is ever raised.
  - Misaligned requests are issued unchanged.

## Structure
- Shared package `dmem_pkg` holds:
  - Ecode constants: ECODE_TLBR, ECODE_PIL, ECODE_PIS, ECODE_PPI, ECODE_PME, ECODE_ALE.
  - FSM state encoding.
  - Size encodings.
- One sub-module `dmem_exc_check`: combinational priority encoder. Inputs are the latched request and the `at_*` results; outputs are `exc_hit` and `exc_ecode`.

## Test plan
- Mapped load, found = v = 1, tlb_plv = 3, req_plv = 0, tag 0x12345, mat 1, dc_ready = 1 → `dc_valid` at cycle 2 with tag 0x12345, `dc_uncached` = 0, `dc_wr` = 0.
- Mapped store, found = 0 → `exc_valid` at cycle 2, ecode 0x3F, badv = vaddr. No `dc_valid`.
- Mapped store, v = 1, d = 0, plv OK → ecode 0x04. Same store with v = 0 → ecode 0x02 (PIS before PME).
- Load with req_plv = 3, tlb_plv = 0 → ecode 0x07. Same load with `at_trans_en` = 0 and `at_direct_mat` = 0 → issued, `dc_uncached` = 1.
- Word load at vaddr 0x1002:
  - With `DMEM_ALIGN_CHECK_EN` → ecode 0x09 even when found = 0.
  - Without it → issued.
- Handshake and flush:
  - `dc_ready` held low for 5 cycles: `dc_valid` and fields stay stable, `req_ready` = 0; on the `dc_ready` cycle, return to IDLE.
  - `flush` in TRANS: no `dc_valid`, no `exc_valid`, `req_ready` = 1 next cycle.
